// File: rtl/clock_alarm_core.sv
// clock_alarm_core: time-of-day engine with BCD HH:MM:SS display, 12/24-hour
// mode, time-set and alarm-set modes, and an alarm with ring timeout and snooze.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   mode_time           level, selects SET_TIME (highest priority)
//   mode_alarm          level, selects SET_ALARM
//   inc_min, inc_hour   rising edges increment the field being edited
//   alarm_en            arms the alarm; low silences it
//   alarm_off           silences the alarm and cancels any snooze
//   snooze              rising edge snoozes a ringing alarm
//   disp_bcd            {h_t,h_u,m_t,m_u,s_t,s_u}; alarm HH:MM:00 in SET_ALARM
//   pm                  pm flag of the displayed value (0 in 24-hour mode)
//   alarm_out           alarm ringing
//   snooze_pending      a snooze re-trigger is armed
//   tick                one-cycle pulse per second while in RUN
//   state               0=RUN, 1=SET_TIME, 2=SET_ALARM
module clock_alarm_core #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned HOUR_24       = 1,
  parameter int unsigned ALARM_TIMEOUT = 60,
  parameter int unsigned SNOOZE_MIN    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_time,
  input  logic        mode_alarm,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        alarm_en,
  input  logic        alarm_off,
  input  logic        snooze,
  output logic [23:0] disp_bcd,
  output logic        pm,
  output logic        alarm_out,
  output logic        snooze_pending,
  output logic        tick,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SET_TIME  = 2'd1,
    ST_SET_ALARM = 2'd2
  } state_e;

  localparam int unsigned      DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [4:0]       HOUR_RST  = (HOUR_24 != 0) ? 5'd0 : 5'd12;
  localparam logic [7:0]       RING_LOAD = 8'(ALARM_TIMEOUT);
  localparam logic [6:0]       SNZ_ADD   = 7'(SNOOZE_MIN);

  // Returns {pm, hour} after one hour step with the mode's wrap rules.
  function automatic logic [5:0] hour_step(input logic [4:0] h, input logic p);
    logic [5:0] r;
    r = {p, h + 5'd1};
    if (HOUR_24 != 0) begin
      if (h == 5'd23) r = 6'd0;
    end else if (h == 5'd11) begin
      r = {~p, 5'd12};
    end else if (h == 5'd12) begin
      r = {p, 5'd1};
    end
    return r;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             pm_q, pm_d;
  logic [5:0]       al_min_q, al_min_d;
  logic [4:0]       al_hour_q, al_hour_d;
  logic             al_pm_q, al_pm_d;
  logic [5:0]       snz_min_q, snz_min_d;
  logic [4:0]       snz_hour_q, snz_hour_d;
  logic             snz_pm_q, snz_pm_d;
  logic [7:0]       ring_q, ring_d;
  logic             alarm_out_q, alarm_out_d;
  logic             snooze_pending_q, snooze_pending_d;
  logic             inc_min_q, inc_min_d, inc_hour_q, inc_hour_d, snooze_q, snooze_d;

  logic       tick_w, min_edge, hour_edge, snz_edge;
  logic       at_zero, alarm_hit, snz_hit;
  logic [5:0] adv_sec, adv_min, hp, tgt_hp, tgt_min;
  logic [4:0] adv_hour;
  logic       adv_pm;
  logic [6:0] snz_sum;

  always_comb begin
    state_d          = state_q;
    div_d            = '0;
    sec_d            = sec_q;
    min_d            = min_q;
    hour_d           = hour_q;
    pm_d             = pm_q;
    al_min_d         = al_min_q;
    al_hour_d        = al_hour_q;
    al_pm_d          = al_pm_q;
    snz_min_d        = snz_min_q;
    snz_hour_d       = snz_hour_q;
    snz_pm_d         = snz_pm_q;
    ring_d           = ring_q;
    alarm_out_d      = alarm_out_q;
    snooze_pending_d = snooze_pending_q;
    inc_min_d        = inc_min;
    inc_hour_d       = inc_hour;
    snooze_d         = snooze;

    min_edge  = inc_min & ~inc_min_q;
    hour_edge = inc_hour & ~inc_hour_q;
    snz_edge  = snooze & ~snooze_q;

    case (state_q)
      ST_RUN: begin
        if (mode_time)       state_d = ST_SET_TIME;
        else if (mode_alarm) state_d = ST_SET_ALARM;
      end
      ST_SET_TIME: begin
        if (!mode_time) state_d = ST_RUN;
      end
      ST_SET_ALARM: begin
        if (mode_time)        state_d = ST_SET_TIME;
        else if (!mode_alarm) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    tick_w = (state_q == ST_RUN) && (div_q == DIV_LAST);
    if (state_q == ST_RUN && !tick_w) div_d = div_q + DIV_ONE;

    // Full ripple of a one-second step; used both to advance and to match.
    adv_sec  = sec_q + 6'd1;
    adv_min  = min_q;
    adv_hour = hour_q;
    adv_pm   = pm_q;
    hp       = hour_step(hour_q, pm_q);
    if (sec_q == 6'd59) begin
      adv_sec = '0;
      if (min_q == 6'd59) begin
        adv_min  = '0;
        adv_hour = hp[4:0];
        adv_pm   = hp[5];
      end else begin
        adv_min = min_q + 6'd1;
      end
    end

    if (tick_w) begin
      sec_d  = adv_sec;
      min_d  = adv_min;
      hour_d = adv_hour;
      pm_d   = adv_pm;
    end

    if (state_q != ST_SET_TIME && state_d == ST_SET_TIME) sec_d = '0;

    if (state_q == ST_SET_TIME) begin
      if (min_edge)  min_d = min_step(min_q);
      if (hour_edge) {pm_d, hour_d} = hp;
    end else if (state_q == ST_SET_ALARM) begin
      if (min_edge)  al_min_d = min_step(al_min_q);
      if (hour_edge) {al_pm_d, al_hour_d} = hour_step(al_hour_q, al_pm_q);
    end

    snz_sum = {1'b0, min_q} + SNZ_ADD;
    if (snz_sum >= 7'd60) begin
      tgt_min = 6'(snz_sum - 7'd60);
      tgt_hp  = hp;
    end else begin
      tgt_min = snz_sum[5:0];
      tgt_hp  = {pm_q, hour_q};
    end

    at_zero   = tick_w && alarm_en && (adv_sec == 6'd0);
    alarm_hit = at_zero && (adv_min == al_min_q) && (adv_hour == al_hour_q)
                && (adv_pm == al_pm_q);
    snz_hit   = at_zero && snooze_pending_q && (adv_min == snz_min_q)
                && (adv_hour == snz_hour_q) && (adv_pm == snz_pm_q);

    if (alarm_off || !alarm_en) begin
      alarm_out_d      = 1'b0;
      snooze_pending_d = 1'b0;
      ring_d           = '0;
    end else begin
      if (alarm_out_q && tick_w) begin
        ring_d = ring_q - 8'd1;
        if (ring_q == 8'd1) alarm_out_d = 1'b0;
      end
      if (snz_edge && alarm_out_q) begin
        alarm_out_d      = 1'b0;
        snooze_pending_d = 1'b1;
        snz_min_d        = tgt_min;
        snz_hour_d       = tgt_hp[4:0];
        snz_pm_d         = tgt_hp[5];
      end
      if (alarm_hit || snz_hit) begin
        alarm_out_d = 1'b1;
        ring_d      = RING_LOAD;
      end
      if (snz_hit) snooze_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      div_q            <= '0;
      sec_q            <= '0;
      min_q            <= '0;
      hour_q           <= HOUR_RST;
      pm_q             <= 1'b0;
      al_min_q         <= '0;
      al_hour_q        <= HOUR_RST;
      al_pm_q          <= 1'b0;
      snz_min_q        <= '0;
      snz_hour_q       <= HOUR_RST;
      snz_pm_q         <= 1'b0;
      ring_q           <= '0;
      alarm_out_q      <= 1'b0;
      snooze_pending_q <= 1'b0;
      inc_min_q        <= 1'b0;
      inc_hour_q       <= 1'b0;
      snooze_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      div_q            <= div_d;
      sec_q            <= sec_d;
      min_q            <= min_d;
      hour_q           <= hour_d;
      pm_q             <= pm_d;
      al_min_q         <= al_min_d;
      al_hour_q        <= al_hour_d;
      al_pm_q          <= al_pm_d;
      snz_min_q        <= snz_min_d;
      snz_hour_q       <= snz_hour_d;
      snz_pm_q         <= snz_pm_d;
      ring_q           <= ring_d;
      alarm_out_q      <= alarm_out_d;
      snooze_pending_q <= snooze_pending_d;
      inc_min_q        <= inc_min_d;
      inc_hour_q       <= inc_hour_d;
      snooze_q         <= snooze_d;
    end
  end

  always_comb begin
    if (state_q == ST_SET_ALARM) begin
      disp_bcd = {to_bcd({1'b0, al_hour_q}), to_bcd(al_min_q), 8'h00};
      pm       = al_pm_q;
    end else begin
      disp_bcd = {to_bcd({1'b0, hour_q}), to_bcd(min_q), to_bcd(sec_q)};
      pm       = pm_q;
    end
  end

  assign alarm_out      = alarm_out_q;
  assign snooze_pending = snooze_pending_q;
  assign tick           = tick_w;
  assign state          = state_q;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core: a 24-hour and a 12-hour instance share
// all inputs; each scenario task checks the instance it targets.
module tb_clock_alarm_core;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mode_time = 1'b0, mode_alarm = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
  logic alarm_en = 1'b0, alarm_off = 1'b0, snooze = 1'b0;

  logic [23:0] disp24, disp12;
  logic        pm24, pm12, ao24, ao12, sp24, sp12, tick24, tick12;
  logic [1:0]  st24, st12;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clock_alarm_core #(.TICK_DIV(TD), .HOUR_24(1), .ALARM_TIMEOUT(60), .SNOOZE_MIN(5)) u24 (
    .clk(clk), .reset(reset), .mode_time(mode_time), .mode_alarm(mode_alarm),
    .inc_min(inc_min), .inc_hour(inc_hour), .alarm_en(alarm_en), .alarm_off(alarm_off),
    .snooze(snooze), .disp_bcd(disp24), .pm(pm24), .alarm_out(ao24),
    .snooze_pending(sp24), .tick(tick24), .state(st24)
  );

  clock_alarm_core #(.TICK_DIV(TD), .HOUR_24(0), .ALARM_TIMEOUT(60), .SNOOZE_MIN(5)) u12 (
    .clk(clk), .reset(reset), .mode_time(mode_time), .mode_alarm(mode_alarm),
    .inc_min(inc_min), .inc_hour(inc_hour), .alarm_en(alarm_en), .alarm_off(alarm_off),
    .snooze(snooze), .disp_bcd(disp12), .pm(pm12), .alarm_out(ao12),
    .snooze_pending(sp12), .tick(tick12), .state(st12)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mode_time = 1'b0; mode_alarm = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    alarm_en = 1'b0; alarm_off = 1'b0; snooze = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      @(negedge clk) inc_min = 1'b1;
      @(negedge clk) inc_min = 1'b0;
    end
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin
      @(negedge clk) inc_hour = 1'b1;
      @(negedge clk) inc_hour = 1'b0;
    end
  endtask

  task automatic set_mode(input logic t, input logic a);
    @(negedge clk);
    mode_time = t; mode_alarm = a;
    @(negedge clk);
  endtask

  // Waits for n ticks (bounded), then one more cycle so the step is visible.
  task automatic run_ticks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc = 0;
    while (seen < n && cyc < n * TD + 2 * TD + 10) begin
      @(negedge clk);
      cyc++;
      if (tick24) seen++;
    end
    vectors++;
    if (seen != n) begin
      miscompares++;
      $display("FAIL tick_wait: got %0d ticks want %0d", seen, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (disp24 !== 24'h000000) begin miscompares++; $display("FAIL reset_disp24: got %h want %h", disp24, 24'h000000); end
    vectors++; if (disp12 !== 24'h120000) begin miscompares++; $display("FAIL reset_disp12: got %h want %h", disp12, 24'h120000); end
    vectors++; if ({pm24, pm12, ao24, sp24, tick24} !== 5'b0) begin miscompares++; $display("FAIL reset_flags: got %b want %b", {pm24, pm12, ao24, sp24, tick24}, 5'b0); end
    vectors++; if (st24 !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", st24, 0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_tick();
    int cyc;
    int last;
    int seen;
    cyc = 0; last = -1; seen = 0;
    while (seen < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tick24) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != TD) begin miscompares++; $display("FAIL tick_period: got %0d want %0d", cyc - last, TD); end
        end
        last = cyc;
        seen++;
      end
    end
    vectors++; if (seen != 10) begin miscompares++; $display("FAIL tick_count: got %0d want %0d", seen, 10); end
    @(negedge clk);
    vectors++; if (disp24 !== 24'h000010) begin miscompares++; $display("FAIL tick_10s: got %h want %h", disp24, 24'h000010); end
  endtask

  task automatic test_rollover_24();
    set_mode(1'b1, 1'b0);
    pulse_hour(23);
    pulse_min(59);
    vectors++; if (disp24 !== 24'h235900) begin miscompares++; $display("FAIL set_2359: got %h want %h", disp24, 24'h235900); end
    vectors++; if (st24 !== 2'd1) begin miscompares++; $display("FAIL set_state: got %0d want %0d", st24, 1); end
    vectors++; if ({disp12, pm12} !== {24'h115900, 1'b1}) begin miscompares++; $display("FAIL set12_1159pm: got %h/%b want %h/%b", disp12, pm12, 24'h115900, 1'b1); end
    set_mode(1'b0, 1'b0);
    vectors++; if (st24 !== 2'd0) begin miscompares++; $display("FAIL run_state: got %0d want %0d", st24, 0); end
    run_ticks(59);
    vectors++; if (disp24 !== 24'h235959) begin miscompares++; $display("FAIL pre_roll: got %h want %h", disp24, 24'h235959); end
    run_ticks(1);
    vectors++; if (disp24 !== 24'h000000) begin miscompares++; $display("FAIL roll_24: got %h want %h", disp24, 24'h000000); end
    vectors++; if ({disp12, pm12} !== {24'h120000, 1'b0}) begin miscompares++; $display("FAIL roll_12_midnight: got %h/%b want %h/%b", disp12, pm12, 24'h120000, 1'b0); end
  endtask

  task automatic test_12h();
    do_reset();
    set_mode(1'b1, 1'b0);
    pulse_hour(11);
    pulse_min(59);
    vectors++; if ({disp12, pm12} !== {24'h115900, 1'b0}) begin miscompares++; $display("FAIL set_1159am: got %h/%b want %h/%b", disp12, pm12, 24'h115900, 1'b0); end
    set_mode(1'b0, 1'b0);
    run_ticks(60);
    vectors++; if ({disp12, pm12} !== {24'h120000, 1'b1}) begin miscompares++; $display("FAIL noon: got %h/%b want %h/%b", disp12, pm12, 24'h120000, 1'b1); end
    vectors++; if ({disp24, pm24} !== {24'h120000, 1'b0}) begin miscompares++; $display("FAIL noon_24: got %h/%b want %h/%b", disp24, pm24, 24'h120000, 1'b0); end
    set_mode(1'b1, 1'b0);
    pulse_min(59);
    vectors++; if ({disp12, pm12} !== {24'h125900, 1'b1}) begin miscompares++; $display("FAIL set_1259pm: got %h/%b want %h/%b", disp12, pm12, 24'h125900, 1'b1); end
    set_mode(1'b0, 1'b0);
    run_ticks(60);
    vectors++; if ({disp12, pm12} !== {24'h010000, 1'b1}) begin miscompares++; $display("FAIL one_pm: got %h/%b want %h/%b", disp12, pm12, 24'h010000, 1'b1); end
    vectors++; if ({disp24, pm24} !== {24'h130000, 1'b0}) begin miscompares++; $display("FAIL 1300_24: got %h/%b want %h/%b", disp24, pm24, 24'h130000, 1'b0); end
  endtask

  task automatic set_alarm_0002();
    do_reset();
    set_mode(1'b0, 1'b1);
    pulse_min(2);
    vectors++; if (st24 !== 2'd2) begin miscompares++; $display("FAIL alarm_state: got %0d want %0d", st24, 2); end
    vectors++; if (disp24 !== 24'h000200) begin miscompares++; $display("FAIL alarm_disp: got %h want %h", disp24, 24'h000200); end
    set_mode(1'b0, 1'b0);
    alarm_en = 1'b1;
  endtask

  task automatic test_alarm();
    int cyc;
    set_alarm_0002();
    run_ticks(119);
    vectors++; if ({disp24, ao24} !== {24'h000159, 1'b0}) begin miscompares++; $display("FAIL pre_alarm: got %h/%b want %h/%b", disp24, ao24, 24'h000159, 1'b0); end
    cyc = 0;
    while (!tick24 && cyc < 2 * TD) begin @(negedge clk); cyc++; end
    vectors++; if (tick24 !== 1'b1) begin miscompares++; $display("FAIL alarm_tick_wait: got %b want %b", tick24, 1'b1); end
    vectors++; if (ao24 !== 1'b0) begin miscompares++; $display("FAIL alarm_early: got %b want %b", ao24, 1'b0); end
    @(negedge clk);
    vectors++; if ({disp24, ao24} !== {24'h000200, 1'b1}) begin miscompares++; $display("FAIL alarm_rise: got %h/%b want %h/%b", disp24, ao24, 24'h000200, 1'b1); end
    run_ticks(59);
    vectors++; if (ao24 !== 1'b1) begin miscompares++; $display("FAIL ring_59: got %b want %b", ao24, 1'b1); end
    run_ticks(1);
    vectors++; if ({disp24, ao24} !== {24'h000300, 1'b0}) begin miscompares++; $display("FAIL ring_timeout: got %h/%b want %h/%b", disp24, ao24, 24'h000300, 1'b0); end
  endtask

  task automatic test_snooze();
    set_alarm_0002();
    run_ticks(120);
    vectors++; if ({ao24, sp24} !== 2'b10) begin miscompares++; $display("FAIL snz_ringing: got %b want %b", {ao24, sp24}, 2'b10); end
    @(negedge clk) snooze = 1'b1;
    @(negedge clk) snooze = 1'b0;
    vectors++; if ({ao24, sp24} !== 2'b01) begin miscompares++; $display("FAIL snz_armed: got %b want %b", {ao24, sp24}, 2'b01); end
    run_ticks(299);
    vectors++; if ({disp24, ao24, sp24} !== {24'h000659, 2'b01}) begin miscompares++; $display("FAIL snz_pre: got %h/%b want %h/%b", disp24, {ao24, sp24}, 24'h000659, 2'b01); end
    run_ticks(1);
    vectors++; if ({disp24, ao24, sp24} !== {24'h000700, 2'b10}) begin miscompares++; $display("FAIL snz_ring: got %h/%b want %h/%b", disp24, {ao24, sp24}, 24'h000700, 2'b10); end
    @(negedge clk) begin alarm_off = 1'b1; snooze = 1'b1; end
    @(negedge clk) begin alarm_off = 1'b0; snooze = 1'b0; end
    vectors++; if ({ao24, sp24} !== 2'b00) begin miscompares++; $display("FAIL off_beats_snz: got %b want %b", {ao24, sp24}, 2'b00); end
    @(negedge clk) snooze = 1'b1;
    @(negedge clk) snooze = 1'b0;
    vectors++; if ({ao24, sp24} !== 2'b00) begin miscompares++; $display("FAIL snz_idle: got %b want %b", {ao24, sp24}, 2'b00); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_mode(1'b1, 1'b0);
    pulse_hour(3);
    vectors++; if (disp24 !== 24'h030000) begin miscompares++; $display("FAIL pre_areset: got %h want %h", disp24, 24'h030000); end
    @(negedge clk) inc_hour = 1'b1;
    #2 reset = 1'b1;
    #1;
    vectors++; if ({disp24, st24} !== {24'h000000, 2'd0}) begin miscompares++; $display("FAIL areset_now: got %h/%0d want %h/%0d", disp24, st24, 24'h000000, 0); end
    vectors++; if ({disp12, pm12, ao24, sp24, tick24} !== {24'h120000, 4'b0}) begin miscompares++; $display("FAIL areset_rest: got %h/%b want %h/%b", disp12, {pm12, ao24, sp24, tick24}, 24'h120000, 4'b0); end
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if ({disp24, st24} !== {24'h000000, 2'd1}) begin miscompares++; $display("FAIL no_spurious_inc: got %h/%0d want %h/%0d", disp24, st24, 24'h000000, 1); end
    vectors++; if ({disp12, pm12} !== {24'h120000, 1'b0}) begin miscompares++; $display("FAIL no_spurious_inc12: got %h/%b want %h/%b", disp12, pm12, 24'h120000, 1'b0); end
    inc_hour = 1'b0;
    mode_time = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_rollover_24();
    test_12h();
    test_alarm();
    test_snooze();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
